// File: rtl/dff_with_reset.sv
// Parameterised D flip-flop with synchronous active-high reset.
// Define DFF_WITH_RESET_CHG_EN to add a registered change flag output (chg).
module dff_with_reset #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef DFF_WITH_RESET_CHG_EN
  ,
  output logic             chg
`endif
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = reset ? RESET_VALUE : d;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

`ifdef DFF_WITH_RESET_CHG_EN
  logic chg_d, chg_q;

  // Reset always clears the flag, even when it moves q.
  always_comb begin
    chg_d = !reset && (d != q_q);
  end

  always_ff @(posedge clk) begin
    chg_q <= chg_d;
  end

  assign chg = chg_q;
`endif

endmodule

// File: tb/tb_dff_with_reset.sv
// Self-checking bench for dff_with_reset: default 8-bit instance checked every cycle
// against a reference model, plus a WIDTH=4 / RESET_VALUE=4'hA instance.
module tb_dff_with_reset;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic [7:0] q;
  logic       reset4;
  logic [3:0] d4;
  logic [3:0] q4;
`ifdef DFF_WITH_RESET_CHG_EN
  logic       chg;
  logic       chg4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_with_reset u_dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
`ifdef DFF_WITH_RESET_CHG_EN
    ,
    .chg   (chg)
`endif
  );

  dff_with_reset #(
    .WIDTH       (4),
    .RESET_VALUE (4'hA)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .d     (d4),
    .q     (q4)
`ifdef DFF_WITH_RESET_CHG_EN
    ,
    .chg   (chg4)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: q is whatever was presented at the last edge (reset value if reset
  // was high); nothing is known until the first edge with reset high.
  logic       model_valid = 1'b0;
  logic [7:0] exp_q;
  logic       exp_chg;

  always @(posedge clk) begin
    if (reset) begin
      exp_chg     = 1'b0;
      exp_q       = 8'h00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_chg = (d != exp_q);
      exp_q   = d;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_q", {56'd0, q}, {56'd0, exp_q});
`ifdef DFF_WITH_RESET_CHG_EN
      check("model_chg", {63'd0, chg}, {63'd0, exp_chg});
`endif
    end
  end

  initial begin
    reset  = 1'b0;
    d      = 8'h00;
    reset4 = 1'b0;
    d4     = 4'h0;

    // Reset with nonzero d
    @(negedge clk);
    reset = 1'b1;
    d     = 8'h01;
    @(negedge clk);
    check("reset_q", {56'd0, q}, 64'h00);
`ifdef DFF_WITH_RESET_CHG_EN
    check("reset_chg", {63'd0, chg}, 64'h0);
`endif

    // Capture: d changes mid low phase, q must not move before the edge
    reset = 1'b0;
    #2 d = 8'h02;
    #1 check("capture_before_edge", {56'd0, q}, 64'h00);
    @(negedge clk);
    check("capture_q", {56'd0, q}, 64'h02);

    // Hold: same d on two edges
    d = 8'h08;
    @(negedge clk);
    check("hold_first_q", {56'd0, q}, 64'h08);
`ifdef DFF_WITH_RESET_CHG_EN
    check("hold_first_chg", {63'd0, chg}, 64'h1);
`endif
    @(negedge clk);
    check("hold_second_q", {56'd0, q}, 64'h08);
`ifdef DFF_WITH_RESET_CHG_EN
    check("hold_second_chg", {63'd0, chg}, 64'h0);
`endif

    // d glitches between edges have no effect, only the value at the edge counts
    d = 8'h3C;
    #1 d = 8'hC3;
    #1 d = 8'h5A;
    #1 check("glitch_hold", {56'd0, q}, 64'h08);
    @(negedge clk);
    check("glitch_capture", {56'd0, q}, 64'h5A);

    // Priority: reset beats d at the same edge
    reset = 1'b1;
    d     = 8'hFF;
    @(negedge clk);
    check("priority_q", {56'd0, q}, 64'h00);
`ifdef DFF_WITH_RESET_CHG_EN
    check("priority_chg", {63'd0, chg}, 64'h0);
`endif

    // Reset held for several edges with changing d
    for (int i = 0; i < 3; i++) begin
      d = 8'h11 * (i + 1);
      @(negedge clk);
      check("reset_held", {56'd0, q}, 64'h00);
    end

    // Short reset pulse inside the low phase is ignored
    reset = 1'b0;
    d     = 8'hA5;
    @(negedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    check("short_pulse", {56'd0, q}, 64'hA5);

    // Sweep 0..127
    for (int i = 0; i < 128; i++) begin
      d = 8'(i);
      @(negedge clk);
    end
    check("sweep_final", {56'd0, q}, 64'h7F);

    // Narrow instance with nonzero reset value
    reset4 = 1'b1;
    d4     = 4'h3;
    @(negedge clk);
    check("w4_reset_q", {60'd0, q4}, 64'hA);
    reset4 = 1'b0;
    d4     = 4'h5;
    @(negedge clk);
    check("w4_capture_q", {60'd0, q4}, 64'h5);
    d4 = 4'hF;
    @(negedge clk);
    check("w4_all_ones", {60'd0, q4}, 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_with_reset.md
DFF_WITH_RESET -- requirements
Module: dff_with_reset

Interface
REQ-001 Parameter: WIDTH, 8, data width in bits; legal range 1..64.
REQ-002 Parameter: RESET_VALUE, {WIDTH{1'b0}}, value loaded into q by reset.
REQ-003 Port: clk  input  1  clock; all state updates on its rising edge only.
REQ-004 Port: reset  input  1  synchronous, active-high reset; one clock, no asynchronous path.
REQ-005 Port: d  input  WIDTH  data to capture.
REQ-006 Port: q  output  WIDTH  registered data; driven directly from a flop, no combinational path from d or reset.
REQ-007 Port: chg  output  1  change flag; present only when DFF_WITH_RESET_CHG_EN is defined.

Function
REQ-008 On each rising clk edge with reset=0, q SHALL take the value d had at that edge (latency 1 cycle).
REQ-009 On each rising clk edge with reset=1, q SHALL become RESET_VALUE regardless of d.
REQ-010 Between rising edges q SHALL hold; d changes away from an edge SHALL NOT affect q.
REQ-011 Reset and a new d at the same edge: reset wins; q=RESET_VALUE.
REQ-012 Reset deassertion SHALL take effect at the next edge: the first edge with reset=0 captures d.
REQ-013 Repeated identical d values SHALL leave q unchanged with no glitch.
REQ-014 Before the first rising edge with reset=1, q is unspecified; verification SHALL NOT check q before that point.
REQ-015 All WIDTH bits SHALL be captured independently; no truncation, sign handling or arithmetic.

Reset
REQ-016 Reset SHALL be sampled only at rising clk edges; a reset pulse not spanning an edge has no effect.
REQ-017 Reset values: q=RESET_VALUE; chg=0 (when compiled in).
REQ-018 Reset asserted for N consecutive edges SHALL hold q=RESET_VALUE for all N edges.

Configuration
REQ-019 Macro DFF_WITH_RESET_CHG_EN: when defined, chg SHALL be a registered output, 1 for exactly the cycle after an edge at which reset=0 and the captured d differs from the previous q, 0 otherwise.
REQ-020 When DFF_WITH_RESET_CHG_EN is defined, an edge with reset=1 SHALL clear chg to 0, even if q changes value.
REQ-021 When DFF_WITH_RESET_CHG_EN is undefined, port chg and its logic SHALL be absent, and q behaviour SHALL be identical.

Verification
REQ-022 Reset: d=8'h01, reset=1 across one rising edge -> q=8'h00 after that edge; chg=0.
REQ-023 Capture: reset=0, d=8'h02 set mid-low-phase -> q=8'h02 after the next rising edge, not before.
REQ-024 Hold: d=8'h08 on two consecutive edges -> q=8'h08 on both; chg=1 after the first edge only (CHG_EN build).
REQ-025 Priority: reset=1 and d=8'hFF at the same edge -> q=8'h00.
REQ-026 Sweep: d=0..127, one value per cycle, reset=0 -> q equals the previous cycle's d every cycle; final q=8'h7F.
REQ-027 Parameter: WIDTH=4, RESET_VALUE=4'hA, reset pulse -> q=4'hA; then d=4'h5 -> q=4'h5 next edge.
